// File: rtl/instr_fetch.sv
// Instruction fetch stage: holds the PC, fetches words over a ready handshake,
// presents them to the decoder and computes the next PC from branch/jump controls.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [5:0]  HALT_OP  = 6'b111111
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrReg,
  output logic        instr_valid,
  input  logic        advance,
  input  logic        Branch,
  input  logic        Jump,
  input  logic        zero,
  // Branch offset in words; named const_imm because const is a reserved word.
  input  logic [15:0] const_imm,
  input  logic [25:0] address,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr_count,
  output logic        halted
);

  typedef enum logic [1:0] {StIdle, StFetch, StValid, StHalted} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] count_q, count_d;
  logic [31:0] branch_off;
  logic [31:0] next_pc;

  assign pc_plus4   = pc_q + 32'd4;
  assign branch_off = {{14{const_imm[15]}}, const_imm, 2'b00};

  // Jump wins over a taken branch.
  always_comb begin
    next_pc = pc_plus4;
    if (Jump) begin
      next_pc = {pc_plus4[31:28], address, 2'b00};
    end else if (Branch && zero) begin
      next_pc = pc_plus4 + branch_off;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    count_d = count_q;
    case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        if (imem_ready) begin
          instr_d = imem_rdata;
          state_d = (imem_rdata[31:26] == HALT_OP) ? StHalted : StValid;
        end
      end
      StValid: begin
        if (advance) begin
          pc_d    = next_pc;
          count_d = count_q + 32'd1;
          state_d = StFetch;
        end
      end
      StHalted: state_d = StHalted;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      count_q <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      count_q <= count_d;
    end
  end

  assign imem_req    = (state_q == StFetch);
  assign instr_valid = (state_q == StValid);
  assign halted      = (state_q == StHalted);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign InstrReg    = instr_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: next-PC vector table, scoreboard of fetched
// words, and hand-written wait-state, halt and reset sequences.
module tb_instr_fetch;

  localparam logic [5:0] HaltOp = 6'b111111;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, hi_req;
  logic [31:0] imem_addr, hi_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr_reg, hi_instr;
  logic        instr_valid, hi_valid;
  logic        advance, branch, jump, zero;
  logic [15:0] const_imm;
  logic [25:0] address;
  logic [31:0] pc, pc_plus4, instr_count;
  logic [31:0] hi_pc, hi_pc_plus4, hi_count;
  logic        halted, hi_halted;

  logic        halt_en;
  logic [31:0] halt_addr;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {6'h01, a[27:2]};
  endfunction

  assign imem_rdata = (halt_en && imem_addr == halt_addr) ? 32'hFC00_0000 : mem_word(imem_addr);

  instr_fetch u_dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .InstrReg   (instr_reg),
    .instr_valid(instr_valid),
    .advance    (advance),
    .Branch     (branch),
    .Jump       (jump),
    .zero       (zero),
    .const_imm  (const_imm),
    .address    (address),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .instr_count(instr_count),
    .halted     (halted)
  );

  // Second instance in the upper address region, for the jump-keeps-top-nibble case.
  instr_fetch #(.RESET_PC(32'h1000_0010)) u_dut_hi (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (hi_req),
    .imem_addr  (hi_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .InstrReg   (hi_instr),
    .instr_valid(hi_valid),
    .advance    (advance),
    .Branch     (branch),
    .Jump       (jump),
    .zero       (zero),
    .const_imm  (const_imm),
    .address    (address),
    .pc         (hi_pc),
    .pc_plus4   (hi_pc_plus4),
    .instr_count(hi_count),
    .halted     (hi_halted)
  );

  typedef struct packed {
    logic        br;
    logic        jp;
    logic        z;
    logic [15:0] imm;
    logic [25:0] addr;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t        vecs[10];
  int          checks = 0;
  int          errors = 0;
  int          exp_count = 0;
  logic [31:0] sb_q[$];
  logic [31:0] sb_exp;
  logic        valid_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: push the word the coming edge captures, then pop on instr_valid rise.
  task automatic cyc();
    if (!rst && imem_req && imem_ready && imem_rdata[31:26] != HaltOp)
      sb_q.push_back(imem_rdata);
    @(posedge clk);
    @(negedge clk);
    if (rst) begin
      sb_q.delete();
      valid_prev = 1'b0;
    end else begin
      if (instr_valid && !valid_prev) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_pop: got instr %h expected no valid instruction", instr_reg);
        end else begin
          sb_exp = sb_q.pop_front();
          chk("sb_instr", instr_reg, sb_exp);
        end
      end
      valid_prev = instr_valid;
    end
  endtask

  task automatic fetch_now();
    imem_ready = 1'b1;
    cyc();
    imem_ready = 1'b0;
    chk("fetch_valid", {31'b0, instr_valid}, 32'd1);
  endtask

  task automatic do_advance(input vec_t v);
    branch    = v.br;
    jump      = v.jp;
    zero      = v.z;
    const_imm = v.imm;
    address   = v.addr;
    advance   = 1'b1;
    cyc();
    advance = 1'b0;
    branch  = 1'b0;
    jump    = 1'b0;
    zero    = 1'b0;
    exp_count++;
    chk("adv_pc", pc, v.exp_pc);
    chk("adv_addr", imem_addr, v.exp_pc);
    chk("adv_req", {31'b0, imem_req}, 32'd1);
    chk("adv_count", instr_count, exp_count);
  endtask

  function automatic vec_t mkv(input logic br, input logic jp, input logic z,
                               input logic [15:0] imm, input logic [25:0] addr,
                               input logic [31:0] exp_pc);
    vec_t v;
    v.br = br; v.jp = jp; v.z = z; v.imm = imm; v.addr = addr; v.exp_pc = exp_pc;
    return v;
  endfunction

  initial begin
    // Chained from pc = 0xC; each expected PC follows from the previous entry.
    vecs[0] = mkv(1'b0, 1'b1, 1'b0, 16'h0000, 26'h000_0010, 32'h0000_0040);
    vecs[1] = mkv(1'b1, 1'b0, 1'b1, 16'hFFFE, 26'h000_0000, 32'h0000_003C);
    vecs[2] = mkv(1'b0, 1'b1, 1'b0, 16'h0000, 26'h000_0010, 32'h0000_0040);
    vecs[3] = mkv(1'b1, 1'b0, 1'b0, 16'hFFFE, 26'h000_0000, 32'h0000_0044);
    vecs[4] = mkv(1'b1, 1'b1, 1'b1, 16'h0005, 26'h000_0040, 32'h0000_0100);
    vecs[5] = mkv(1'b1, 1'b0, 1'b1, 16'h8000, 26'h000_0000, 32'hFFFE_0104);
    vecs[6] = mkv(1'b0, 1'b0, 1'b1, 16'h1234, 26'h3FF_FFFF, 32'hFFFE_0108);
    vecs[7] = mkv(1'b0, 1'b1, 1'b0, 16'h0000, 26'h3FF_FFFF, 32'hFFFF_FFFC);
    vecs[8] = mkv(1'b0, 1'b0, 1'b0, 16'h0000, 26'h000_0000, 32'h0000_0000);
    vecs[9] = mkv(1'b1, 1'b0, 1'b1, 16'h7FFF, 26'h000_0000, 32'h0002_0000);

    rst = 1'b1; imem_ready = 1'b0; advance = 1'b0; branch = 1'b0; jump = 1'b0;
    zero = 1'b0; const_imm = 16'h0; address = 26'h0; halt_en = 1'b0; halt_addr = 32'h0;
    @(negedge clk);
    cyc();
    cyc();
    chk("rst_pc", pc, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_pc_plus4", pc_plus4, 32'h4);
    chk("rst_instr", instr_reg, 32'h0);
    chk("rst_count", instr_count, 32'h0);
    chk("rst_flags", {29'b0, imem_req, instr_valid, halted}, 32'h0);
    chk("rst_hi_pc", hi_pc, 32'h1000_0010);
    chk("rst_hi_pc_plus4", hi_pc_plus4, 32'h1000_0014);

    rst = 1'b0;
    cyc();
    chk("first_req", {31'b0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h0);

    // Jump overrides a taken branch and keeps the PC's top nibble.
    fetch_now();
    branch = 1'b1; jump = 1'b1; zero = 1'b1; const_imm = 16'h0005; address = 26'h000_0040;
    advance = 1'b1;
    cyc();
    advance = 1'b0; branch = 1'b0; jump = 1'b0; zero = 1'b0;
    chk("jprio_hi_pc", hi_pc, 32'h1000_0100);
    chk("jprio_hi_addr", hi_addr, 32'h1000_0100);
    chk("jprio_pc", pc, 32'h0000_0100);

    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();

    // Sequential fetch with ready and advance tied high.
    imem_ready = 1'b1;
    advance    = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      if (k % 2 == 1) begin
        chk("seq_valid", {30'b0, imem_req, instr_valid}, 32'b01);
      end else begin
        chk("seq_req", {31'b0, imem_req}, 32'd1);
        chk("seq_addr", imem_addr, 32'(4 * (k / 2)));
      end
    end
    chk("seq_count", instr_count, 32'd3);
    exp_count = 3;

    // Wait states; advance in FETCH must be ignored.
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("wait_req", {31'b0, imem_req}, 32'd1);
      chk("wait_addr", imem_addr, 32'hC);
      chk("wait_instr", instr_reg, mem_word(32'h8));
      chk("wait_count", instr_count, 32'd3);
    end
    advance = 1'b0;
    fetch_now();
    chk("wait_capture", instr_reg, mem_word(32'hC));

    for (int i = 0; i < 10; i++) begin
      do_advance(vecs[i]);
      fetch_now();
    end

    // Halt: the word at 0x20004 carries the halt opcode.
    halt_en   = 1'b1;
    halt_addr = 32'h0002_0004;
    do_advance(mkv(1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0002_0004));
    imem_ready = 1'b1;
    cyc();
    chk("halt_flags", {29'b0, halted, imem_req, instr_valid}, 32'b100);
    chk("halt_instr", instr_reg, 32'hFC00_0000);
    advance = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("halt_pc", pc, 32'h0002_0004);
      chk("halt_count", instr_count, exp_count);
      chk("halt_stay", {31'b0, halted}, 32'd1);
    end
    advance = 1'b0; imem_ready = 1'b0; halt_en = 1'b0;

    // Reset asserted mid-fetch, with a late ready while reset is held.
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    fetch_now();
    exp_count = 0;
    do_advance(mkv(1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h4));
    cyc();
    rst = 1'b1;
    #1;
    chk("mrst_pc", pc, 32'h0);
    chk("mrst_count", instr_count, 32'h0);
    chk("mrst_req", {31'b0, imem_req}, 32'd0);
    imem_ready = 1'b1;
    cyc();
    cyc();
    chk("mrst_hold_pc", pc, 32'h0);
    chk("mrst_hold_instr", instr_reg, 32'h0);
    chk("mrst_hold_flags", {30'b0, imem_req, instr_valid}, 32'b0);
    imem_ready = 1'b0;
    rst = 1'b0;
    cyc();
    chk("mrst_req_after", {31'b0, imem_req}, 32'd1);
    chk("mrst_addr_after", imem_addr, 32'h0);
    chk("mrst_instr_after", instr_reg, 32'h0);
    fetch_now();
    chk("mrst_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
